ioctl_dl_router: RTL and testbench
==================================

Name: ioctl_dl_router

Overview:
- Generalised successor to the single-target ioctl download hookup in the core top level.
- Accepts the HPS ioctl byte stream and routes each download by ioctl_index to one of NCH target write ports.
- Optionally strips a fixed file header (e.g. the 128-byte TAP header), relocates bytes to a per-channel base address, and buffers them in a small FIFO.
- Drives ioctl_wait back to hps_io as flow control.

Parameters:
- NCH, 3: number of target channels.
- AW, 16: target address width.
- DEPTH, 4: FIFO depth in entries; power of 2, ≥ 2.
- CH_INDEX, {8'd2,8'd1,8'd0}: packed NCH×8; ioctl_index value served by each channel.
- SKIP_MASK, 3'b010: per-channel enable for header skip.
- HDR_SKIP, 128: number of leading bytes dropped on skip-enabled channels.

Ports:
- clk_sys  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- ioctl_download  in  1  download active (from hps_io)
- ioctl_index  in  8  file index
- ioctl_wr  in  1  byte strobe
- ioctl_addr  in  25  byte offset within file
- ioctl_data  in  8  byte value
- ioctl_wait  out  1  flow control to hps_io
- ch_base  in  NCH×AW  per-channel base address; static during a download
- t_req  out  NCH  write request, one-hot
- t_addr  out  AW  target address
- t_data  out  8  target data
- t_ack  in  NCH  one-cycle accept from the target
- dl_busy  out  1  state ≠ IDLE
- dl_done  out  1  one-cycle pulse at end of download
- dl_len  out  25  bytes delivered to the target
- err  out  1  sticky overflow / address-range error

Behaviour:
- Reset (async): state IDLE, FIFO empty. Outputs: ioctl_wait=0, t_req=0, t_addr=0, t_data=0, dl_busy=0, dl_done=0, dl_len=0, err=0.
- States:
  - IDLE: on ioctl_download=1 (level, sampled each clk), latch the channel whose CH_INDEX matches ioctl_index (lowest channel wins on duplicates). Clear dl_len and err.
    - No match → IGNORE.
    - Match with SKIP_MASK bit set → SKIP.
    - Otherwise → STREAM.
  - IGNORE: consume every ioctl_wr with no effect and ioctl_wait=0. On ioctl_download=0 → IDLE. No dl_done.
  - SKIP: drop writes with ioctl_addr < HDR_SKIP. On the first write with ioctl_addr ≥ HDR_SKIP, push that byte and go to STREAM in the same cycle.
  - STREAM: on each ioctl_wr, push {addr, data}. On ioctl_download=0 → DRAIN.
  - DRAIN: no pushes; ioctl_wait=1. When the FIFO is empty → DONE.
  - DONE: one cycle with dl_done=1, ioctl_wait=1, then → IDLE.
- Address computation: off = ioctl_addr − (skip ? HDR_SKIP : 0). t_addr = ch_base[ch] + off[AW-1:0], modulo 2^AW.
  - If off ≥ 2^AW: byte dropped, err set. err is sticky until the next download start.
- FIFO: push and pop may occur in the same cycle; count is unchanged in that case.
  - ioctl_wait = (free ≤ 1) in SKIP/STREAM, so exactly one in-flight write after wait rises is absorbed.
  - A write arriving with FIFO full is dropped and sets err.
- Target handshake:
  - When the FIFO is non-empty, t_req[ch]=1 and t_addr/t_data present the FIFO head, registered.
  - t_req, t_addr and t_data are held stable until t_ack[ch]=1; that cycle pops the entry. Next head is visible the following cycle, giving 1-cycle bubble-free throughput with continuous ack.
  - t_ack on an unrequested channel, or with FIFO empty, is ignored.
- dl_len increments on every successful push; held after DONE until the next download start.
- Latency: ioctl_wr to t_req = 2 clk with the FIFO previously empty.
- Download rising during DRAIN/DONE: not started until IDLE; ioctl_wait stays 1 meanwhile.
- Reset mid-download: all state cleared immediately, pending entries discarded, t_req drops asynchronously. Targets must tolerate an abandoned request.

Decomposition:
- Package kc_dl_pkg:
  - state enum (IDLE, IGNORE, SKIP, STREAM, DRAIN, DONE)
  - index constants IDX_ROM=0, IDX_TAP=1, IDX_RAM=2
  - TAP_HDR_LEN=128
- Sub-module dl_fifo: synchronous FIFO parametrised on width and DEPTH, exposing count/full/empty, with async reset.

Test Plan:
- Index 0, 16 bytes 0x00..0x0F, ch_base[0]=0x0000, t_ack tied high → t_addr 0x0000..0x000F with matching data; dl_len=16; one dl_done pulse; err=0.
- Index 1 (skip), 130-byte file, ch_base[1]=0x0300 → only 2 writes, at 0x0300/0x0301 carrying file bytes 128/129; dl_len=2.
- Index 0, t_ack held low for 20 clk, continuous ioctl_wr → ioctl_wait rises at free ≤ 1, no loss, err=0; releasing ack delivers all bytes in order.
- Index 7 (unmapped), 8 writes → no t_req, ioctl_wait=0 throughout, no dl_done, dl_len=0.
- AW=8, index 2, 300-byte file → 256 bytes delivered, err=1, dl_len=256.
- Assert reset while 3 entries are queued → t_req=0 at once, FIFO empty; next download proceeds normally from dl_len=0.

Source files
------------

// File: rtl/kc_dl_pkg.sv
// Shared types and constants for the ioctl download router.
package kc_dl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        IGNORE,
        SKIP,
        STREAM,
        DRAIN,
        DONE
    } dl_state_e;

    localparam logic [7:0] IDX_ROM = 8'd0;
    localparam logic [7:0] IDX_TAP = 8'd1;
    localparam logic [7:0] IDX_RAM = 8'd2;

    localparam int unsigned TAP_HDR_LEN = 128;

endpackage

// File: rtl/dl_fifo.sv
// Small synchronous FIFO with occupancy count; push and pop may coincide.
module dl_fifo #(
    parameter  int unsigned W     = 8,
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PW    = $clog2(DEPTH),
    localparam int unsigned CW    = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/ioctl_dl_router.sv
// Routes the hps_io ioctl download stream to one of NCH target write ports,
// with optional header skip, per-channel relocation and a small FIFO.
module ioctl_dl_router
    import kc_dl_pkg::*;
#(
    parameter int unsigned        NCH       = 3,
    parameter int unsigned        AW        = 16,
    parameter int unsigned        DEPTH     = 4,
    parameter logic [NCH*8-1:0]   CH_INDEX  = {IDX_RAM, IDX_TAP, IDX_ROM},
    parameter logic [NCH-1:0]     SKIP_MASK = 3'b010,
    parameter int unsigned        HDR_SKIP  = TAP_HDR_LEN
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              ioctl_download,
    input  logic [7:0]        ioctl_index,
    input  logic              ioctl_wr,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_data,
    output logic              ioctl_wait,
    input  logic [NCH*AW-1:0] ch_base,
    output logic [NCH-1:0]    t_req,
    output logic [AW-1:0]     t_addr,
    output logic [7:0]        t_data,
    input  logic [NCH-1:0]    t_ack,
    output logic              dl_busy,
    output logic              dl_done,
    output logic [24:0]       dl_len,
    output logic              err
);

    localparam int unsigned LW  = 25;
    localparam int unsigned FW  = AW + 8;
    localparam int unsigned CHW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned CW  = $clog2(DEPTH) + 1;

    dl_state_e       state;
    logic [CHW-1:0]  ch_r;
    logic            skip_r;

    logic            hit;
    logic [CHW-1:0]  hit_ch;
    logic [LW-1:0]   off;
    logic            in_range;
    logic            hdr_ok;
    logic            wr_live;
    logic            push;
    logic            pop;
    logic            ack_hit;
    logic            err_set;
    logic [AW-1:0]   dest;
    logic [CW-1:0]   count_n;
    logic [CW-1:0]   free_n;
    logic            wait_n;

    logic [FW-1:0]   fifo_dout;
    logic [CW-1:0]   fifo_count;
    logic            fifo_full;
    logic            fifo_empty;

    // Channel lookup; scanning downwards lets the lowest matching channel win.
    always_comb begin
        hit    = 1'b0;
        hit_ch = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (CH_INDEX[i*8 +: 8] == ioctl_index) begin
                hit    = 1'b1;
                hit_ch = CHW'(i);
            end
        end
    end

    assign off      = ioctl_addr - (skip_r ? LW'(HDR_SKIP) : LW'(0));
    assign in_range = ((off >> AW) == '0);
    assign hdr_ok   = (ioctl_addr >= LW'(HDR_SKIP));
    assign dest     = ch_base[ch_r*AW +: AW] + AW'(off);
    assign wr_live  = ioctl_wr && ((state == STREAM) || ((state == SKIP) && hdr_ok));
    assign push     = wr_live && in_range && !fifo_full;
    assign err_set  = wr_live && (!in_range || fifo_full);

    // The output register is the head stage: reload it when empty or accepted.
    assign ack_hit  = |(t_req & t_ack);
    assign pop      = !fifo_empty && ((t_req == '0) || ack_hit);

    assign count_n  = fifo_count + CW'(push) - CW'(pop);
    assign free_n   = CW'(DEPTH) - count_n;
    assign wait_n   = (free_n <= CW'(1));

    dl_fifo #(
        .W     (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk_sys),
        .rst   (reset),
        .push  (push),
        .din   ({dest, ioctl_data}),
        .pop   (pop),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            ch_r       <= '0;
            skip_r     <= 1'b0;
            ioctl_wait <= 1'b0;
            t_req      <= '0;
            t_addr     <= '0;
            t_data     <= '0;
            dl_busy    <= 1'b0;
            dl_done    <= 1'b0;
            dl_len     <= '0;
            err        <= 1'b0;
        end else begin
            dl_done <= 1'b0;

            if (pop) begin
                t_req  <= NCH'(1) << ch_r;
                t_addr <= fifo_dout[FW-1:8];
                t_data <= fifo_dout[7:0];
            end else if (ack_hit) begin
                t_req <= '0;
            end

            case (state)
                IDLE: begin
                    ioctl_wait <= 1'b0;
                    if (ioctl_download) begin
                        ch_r    <= hit_ch;
                        skip_r  <= hit && SKIP_MASK[hit_ch];
                        dl_len  <= '0;
                        err     <= 1'b0;
                        dl_busy <= 1'b1;
                        if (!hit)                   state <= IGNORE;
                        else if (SKIP_MASK[hit_ch]) state <= SKIP;
                        else                        state <= STREAM;
                    end
                end
                IGNORE: begin
                    ioctl_wait <= 1'b0;
                    if (!ioctl_download) begin
                        state   <= IDLE;
                        dl_busy <= 1'b0;
                    end
                end
                SKIP, STREAM: begin
                    if (!ioctl_download) begin
                        state      <= DRAIN;
                        ioctl_wait <= 1'b1;
                    end else begin
                        ioctl_wait <= wait_n;
                        if (state == SKIP && ioctl_wr && hdr_ok) state <= STREAM;
                    end
                end
                DRAIN: begin
                    ioctl_wait <= 1'b1;
                    if (fifo_empty && (t_req == '0)) begin
                        state   <= DONE;
                        dl_done <= 1'b1;
                    end
                end
                DONE: begin
                    state      <= IDLE;
                    ioctl_wait <= 1'b0;
                    dl_busy    <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    dl_busy <= 1'b0;
                end
            endcase

            // Pushes and errors only occur in SKIP/STREAM, never alongside the IDLE clear.
            if (push)    dl_len <= dl_len + 25'd1;
            if (err_set) err    <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ioctl_dl_router.sv
// Directed bench for ioctl_dl_router: routing, header skip, flow control,
// address-range errors, unmapped index and mid-download reset.
module tb_ioctl_dl_router;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        ioctl_download;
    logic        ioctl_download8;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_data;

    logic        ioctl_wait;
    logic [47:0] ch_base;
    logic [2:0]  t_req;
    logic [15:0] t_addr;
    logic [7:0]  t_data;
    logic [2:0]  t_ack;
    logic        dl_busy;
    logic        dl_done;
    logic [24:0] dl_len;
    logic        err;

    logic        ioctl_wait8;
    logic [23:0] ch_base8;
    logic [2:0]  t_req8;
    logic [7:0]  t_addr8;
    logic [7:0]  t_data8;
    logic [2:0]  t_ack8;
    logic        dl_busy8;
    logic        dl_done8;
    logic [24:0] dl_len8;
    logic        err8;

    int checks = 0;
    int errors = 0;

    logic [15:0] cap_addr[$];
    logic [7:0]  cap_data[$];
    logic [2:0]  cap_req[$];
    int          done_cnt;
    bit          req_seen;
    bit          wait_seen;
    int          n8;
    logic [7:0]  last_addr8;
    logic [7:0]  last_data8;

    always #5 clk_sys = ~clk_sys;

    ioctl_dl_router dut (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .ioctl_index    (ioctl_index),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_data     (ioctl_data),
        .ioctl_wait     (ioctl_wait),
        .ch_base        (ch_base),
        .t_req          (t_req),
        .t_addr         (t_addr),
        .t_data         (t_data),
        .t_ack          (t_ack),
        .dl_busy        (dl_busy),
        .dl_done        (dl_done),
        .dl_len         (dl_len),
        .err            (err)
    );

    ioctl_dl_router #(.AW(8)) dut8 (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .ioctl_download (ioctl_download8),
        .ioctl_index    (ioctl_index),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_data     (ioctl_data),
        .ioctl_wait     (ioctl_wait8),
        .ch_base        (ch_base8),
        .t_req          (t_req8),
        .t_addr         (t_addr8),
        .t_data         (t_data8),
        .t_ack          (t_ack8),
        .dl_busy        (dl_busy8),
        .dl_done        (dl_done8),
        .dl_len         (dl_len8),
        .err            (err8)
    );

    // Target-side monitor, sampled mid-cycle.
    always @(negedge clk_sys) begin
        if ((t_req & t_ack) != 3'b000) begin
            cap_addr.push_back(t_addr);
            cap_data.push_back(t_data);
            cap_req.push_back(t_req);
        end
        if (t_req != 3'b000) req_seen = 1'b1;
        if (ioctl_wait)      wait_seen = 1'b1;
        if (dl_done)         done_cnt++;
        if ((t_req8 & t_ack8) != 3'b000) begin
            n8++;
            last_addr8 = t_addr8;
            last_data8 = t_data8;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic clear_mon();
        cap_addr.delete();
        cap_data.delete();
        cap_req.delete();
        done_cnt  = 0;
        req_seen  = 1'b0;
        wait_seen = 1'b0;
        n8        = 0;
    endtask

    // One byte strobe, honouring ioctl_wait of the selected instance.
    task automatic wr_byte(input bit use8, input logic [24:0] a, input logic [7:0] d);
        int guard = 0;
        while ((use8 ? ioctl_wait8 : ioctl_wait) && guard < 1000) begin
            tick();
            guard++;
        end
        if (guard >= 1000) begin
            checks++;
            errors++;
            $error("FAIL wait_timeout: observed wait stuck high, expected release");
        end
        ioctl_wr   = 1'b1;
        ioctl_addr = a;
        ioctl_data = d;
        tick();
        ioctl_wr   = 1'b0;
    endtask

    task automatic start_dl(input bit use8, input logic [7:0] idx);
        ioctl_index = idx;
        if (use8) ioctl_download8 = 1'b1;
        else      ioctl_download  = 1'b1;
        tick();
    endtask

    task automatic end_dl(input bit use8);
        int guard = 0;
        if (use8) ioctl_download8 = 1'b0;
        else      ioctl_download  = 1'b0;
        tick();
        while ((use8 ? dl_busy8 : dl_busy) && guard < 500) begin
            tick();
            guard++;
        end
        if (guard >= 500) begin
            checks++;
            errors++;
            $error("FAIL busy_timeout: observed dl_busy stuck high, expected idle");
        end
        tick();
    endtask

    initial begin
        reset           = 1'b1;
        ioctl_download  = 1'b0;
        ioctl_download8 = 1'b0;
        ioctl_index     = 8'd0;
        ioctl_wr        = 1'b0;
        ioctl_addr      = '0;
        ioctl_data      = '0;
        ch_base         = '0;
        t_ack           = 3'b000;
        ch_base8        = {8'h10, 8'h00, 8'h00};
        t_ack8          = 3'b111;
        clear_mon();
        repeat (3) tick();

        // Reset state
        check("rst_wait",  32'(ioctl_wait), 32'd0);
        check("rst_treq",  32'(t_req),      32'd0);
        check("rst_taddr", 32'(t_addr),     32'd0);
        check("rst_tdata", 32'(t_data),     32'd0);
        check("rst_flags", {29'd0, dl_busy, dl_done, err}, 32'd0);
        check("rst_len",   32'(dl_len),     32'd0);
        #2 reset = 1'b0;
        tick();

        // Index 0, 16 bytes, ack tied high
        clear_mon();
        t_ack = 3'b111;
        start_dl(1'b0, 8'd0);
        check("t1_busy", 32'(dl_busy), 32'd1);
        wr_byte(1'b0, 25'd0, 8'h00);
        check("t1_lat1", 32'(t_req), 32'd0);
        tick();
        check("t1_lat2", 32'(t_req), 32'b001);
        check("t1_addr0", 32'(t_addr), 32'h0000);
        for (int i = 1; i < 16; i++) wr_byte(1'b0, 25'(i), 8'(i));
        end_dl(1'b0);
        check("t1_count", 32'(cap_addr.size()), 32'd16);
        for (int i = 0; i < 16 && i < cap_addr.size(); i++)
            check($sformatf("t1_byte%0d", i), {8'd0, cap_addr[i], cap_data[i]}, {8'd0, 16'(i), 8'(i)});
        check("t1_len",  32'(dl_len),  32'd16);
        check("t1_done", 32'(done_cnt), 32'd1);
        check("t1_err",  32'(err),     32'd0);

        // Index 1 with 128-byte header skip
        clear_mon();
        ch_base[31:16] = 16'h0300;
        start_dl(1'b0, 8'd1);
        for (int i = 0; i < 130; i++) wr_byte(1'b0, 25'(i), 8'(i));
        end_dl(1'b0);
        check("t2_count", 32'(cap_addr.size()), 32'd2);
        if (cap_addr.size() >= 2) begin
            check("t2_b0", {8'd0, cap_addr[0], cap_data[0]}, {8'd0, 16'h0300, 8'h80});
            check("t2_b1", {8'd0, cap_addr[1], cap_data[1]}, {8'd0, 16'h0301, 8'h81});
            check("t2_req", 32'(cap_req[0]), 32'b010);
        end
        check("t2_len",  32'(dl_len),   32'd2);
        check("t2_done", 32'(done_cnt), 32'd1);

        // Index 0 with ack held low for 20 clocks: flow control, no loss
        clear_mon();
        ch_base[15:0] = 16'h1000;
        t_ack = 3'b000;
        start_dl(1'b0, 8'd0);
        fork
            begin
                for (int i = 0; i < 12; i++) wr_byte(1'b0, 25'(i), 8'(8'h40 + i));
            end
            begin
                repeat (20) tick();
                check("t3_wait_hi", 32'(ioctl_wait), 32'd1);
                check("t3_hold",    {13'd0, t_req, t_addr}, {13'd0, 3'b001, 16'h1000});
                t_ack = 3'b001;
            end
        join
        end_dl(1'b0);
        check("t3_count", 32'(cap_addr.size()), 32'd12);
        for (int i = 0; i < 12 && i < cap_addr.size(); i++)
            check($sformatf("t3_byte%0d", i), {8'd0, cap_addr[i], cap_data[i]},
                  {8'd0, 16'(16'h1000 + i), 8'(8'h40 + i)});
        check("t3_err", 32'(err),    32'd0);
        check("t3_len", 32'(dl_len), 32'd12);

        // Unmapped index 7
        clear_mon();
        t_ack = 3'b111;
        start_dl(1'b0, 8'd7);
        for (int i = 0; i < 8; i++) wr_byte(1'b0, 25'(i), 8'hEE);
        end_dl(1'b0);
        check("t4_req",  32'(req_seen),  32'd0);
        check("t4_wait", 32'(wait_seen), 32'd0);
        check("t4_done", 32'(done_cnt),  32'd0);
        check("t4_len",  32'(dl_len),    32'd0);

        // AW=8 instance, index 2, 300 bytes: top 44 out of range
        clear_mon();
        start_dl(1'b1, 8'd2);
        for (int i = 0; i < 300; i++) wr_byte(1'b1, 25'(i), 8'(i));
        end_dl(1'b1);
        check("t5_n",    32'(n8),      32'd256);
        check("t5_len",  32'(dl_len8), 32'd256);
        check("t5_err",  32'(err8),    32'd1);
        check("t5_last", {16'd0, last_addr8, last_data8}, {16'd0, 8'h0F, 8'hFF});

        // Reset with 3 entries queued
        clear_mon();
        ch_base[15:0] = 16'h0000;
        t_ack = 3'b000;
        start_dl(1'b0, 8'd0);
        for (int i = 0; i < 3; i++) wr_byte(1'b0, 25'(i), 8'(8'h90 + i));
        tick();
        check("t6_pre", 32'(t_req), 32'b001);
        ioctl_download = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("t6_async_req", 32'(t_req), 32'd0);
        check("t6_async_busy", 32'(dl_busy), 32'd0);
        #2 reset = 1'b0;
        t_ack = 3'b111;
        clear_mon();
        repeat (4) tick();
        check("t6_empty", 32'(req_seen), 32'd0);
        start_dl(1'b0, 8'd0);
        check("t6_len0", 32'(dl_len), 32'd0);
        for (int i = 0; i < 4; i++) wr_byte(1'b0, 25'(i), 8'(8'hC0 + i));
        end_dl(1'b0);
        check("t6_count", 32'(cap_addr.size()), 32'd4);
        for (int i = 0; i < 4 && i < cap_addr.size(); i++)
            check($sformatf("t6_byte%0d", i), {8'd0, cap_addr[i], cap_data[i]},
                  {8'd0, 16'(i), 8'(8'hC0 + i)});
        check("t6_len",  32'(dl_len),   32'd4);
        check("t6_done", 32'(done_cnt), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
